out_uart: RTL and testbench

- Output stage directly downstream of the CPU control unit.
- Captures the accumulator word the CPU presents on its output-instruction data bus (cu_data), using a one-cycle write strobe. Buffers words in a small FIFO.
- Serialises each word on a UART TX line as d/8 bytes, least-significant byte first, in 8N1 format.
- Lets the CPU run at full speed while the slow serial line drains.

---
 rtl/out_uart.sv | 159 +++++++++++++++
 tb/tb_out_uart.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_uart.sv
// Output stage behind the CPU control unit: buffers written words in a small
// FIFO and sends each one as d/8 UART 8N1 frames, least-significant byte first.
module out_uart #(
  parameter int d            = 16,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [d-1:0] din,
  output logic         tx,
  output logic         busy,
  output logic         full,
  output logic         empty,
  output logic         overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NB = d / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [d-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  state_t        r_state;
  logic [d-1:0]  r_shift;
  logic [KW-1:0] r_clkCnt;
  logic [2:0]    r_bitIdx;
  logic [BW-1:0] r_byteIdx;
  logic          r_tx;

  logic          w_pop;
  logic          w_push;
  logic          w_bitDone;
  logic [CW-1:0] w_countNext;

  // A write into a full FIFO still lands when the serialiser frees a slot on the same edge.
  assign w_pop     = (r_state == IDLE) && !r_empty;
  assign w_push    = wr && (!r_full || w_pop);
  assign w_bitDone = (r_clkCnt == KW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop)
      w_countNext = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_countNext = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)
        r_rdPtr <= r_rdPtr + PW'(1);
      if (wr && !w_push)
        r_overflow <= 1'b1;
      r_count <= w_countNext;
      r_full  <= (w_countNext == CW'(DEPTH));
      r_empty <= (w_countNext == '0);
    end
  end

  // After eight right shifts the next byte of the word already sits in the low bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_clkCnt  <= '0;
      r_bitIdx  <= '0;
      r_byteIdx <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= r_mem[r_rdPtr];
            r_byteIdx <= '0;
            r_clkCnt  <= '0;
            r_state   <= START;
            r_tx      <= 1'b0;
          end
        end
        START: begin
          if (w_bitDone) begin
            r_clkCnt <= '0;
            r_bitIdx <= '0;
            r_state  <= DATA;
            r_tx     <= r_shift[0];
          end else begin
            r_clkCnt <= r_clkCnt + KW'(1);
          end
        end
        DATA: begin
          if (w_bitDone) begin
            r_clkCnt <= '0;
            r_shift  <= r_shift >> 1;
            if (r_bitIdx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_tx     <= r_shift[1];
            end
          end else begin
            r_clkCnt <= r_clkCnt + KW'(1);
          end
        end
        STOP: begin
          if (w_bitDone) begin
            r_clkCnt <= '0;
            if (r_byteIdx < BW'(NB - 1)) begin
              r_byteIdx <= r_byteIdx + BW'(1);
              r_state   <= START;
              r_tx      <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_clkCnt <= r_clkCnt + KW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign full     = r_full;
  assign empty    = r_empty;
  assign overflow = r_overflow;
  assign busy     = (r_state != IDLE) || !r_empty;

endmodule

// File: tb/tb_out_uart.sv
// Self-checking bench for out_uart: a UART receiver model decodes tx and
// checks each byte against a scoreboard filled as words are written.
module tb_out_uart;
  localparam int CPB = 4;
  localparam int DW  = 16;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] din = '0;
  logic          tx;
  logic          busy;
  logic          full;
  logic          empty;
  logic          overflow;

  int            asserts = 0;
  int            failures = 0;
  logic [7:0]    sbQ[$];
  int            startLog[$];
  int            sampleCyc = 0;
  int            rxN = 0;
  logic          rxActive = 1'b0;
  logic          rxBit = 1'b1;
  logic [7:0]    rxByte = '0;
  vec_t          vecs[20];

  out_uart #(.d(DW), .DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .wr(wr), .din(din), .tx(tx),
    .busy(busy), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one write that the next edge samples.
  task automatic applyStimulus(input vec_t v, input logic accept);
    wr  = 1'b1;
    din = v.word;
    if (accept) begin
      sbQ.push_back(v.lo);
      sbQ.push_back(v.hi);
    end
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic resetDut();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sbQ.delete();
    checkOutput("rstTx", tx, 1);
    checkOutput("rstEmpty", empty, 1);
    checkOutput("rstFull", full, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOverflow", overflow, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget && !(sbQ.size() == 0 && !busy && !rxActive); i++)
      @(posedge clk);
    #1;
    checkOutput(name, sbQ.size(), 0);
    checkOutput({name, "Busy"}, busy, 0);
  endtask

  // Receiver: samples on falling edges, so every bit spans exactly CPB samples.
  always @(negedge clk) begin
    sampleCyc++;
    if (!reset) begin
      rxActive = 1'b0;
    end else begin
      if (!rxActive && tx == 1'b0) begin
        rxActive = 1'b1;
        rxN = 0;
        startLog.push_back(sampleCyc);
      end else if (rxActive) begin
        rxN++;
      end
      if (rxActive) begin
        if (rxN % CPB == 0) begin
          rxBit = tx;
          if (rxN / CPB >= 1 && rxN / CPB <= 8)
            rxByte[rxN / CPB - 1] = tx;
        end else begin
          checkOutput("bitWidth", tx, rxBit);
        end
        if (rxN == 10 * CPB - 1) begin
          checkOutput("stopBit", rxBit, 1);
          asserts++;
          if (sbQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL rxByte: got %02h, expected no byte at %0t", rxByte, $time);
          end else begin
            logic [7:0] expB;
            expB = sbQ.pop_front();
            if (rxByte !== expB) begin
              failures++;
              $display("[TB] FAIL rxByte: got %02h, expected %02h at %0t", rxByte, expB, $time);
            end
          end
          rxActive = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int windowStart;
    int maxSpacing;
    vecs[0]  = '{16'hA55A, 8'h5A, 8'hA5};
    vecs[1]  = '{16'h0001, 8'h01, 8'h00};
    vecs[2]  = '{16'h8000, 8'h00, 8'h80};
    vecs[3]  = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[4]  = '{16'h1234, 8'h34, 8'h12};
    vecs[5]  = '{16'h5678, 8'h78, 8'h56};
    vecs[6]  = '{16'h9ABC, 8'hBC, 8'h9A};
    vecs[7]  = '{16'hDEF0, 8'hF0, 8'hDE};
    vecs[8]  = '{16'h0F0F, 8'h0F, 8'h0F};
    vecs[9]  = '{16'hF0F0, 8'hF0, 8'hF0};
    vecs[10] = '{16'h1111, 8'h11, 8'h11};
    vecs[11] = '{16'h2222, 8'h22, 8'h22};
    vecs[12] = '{16'h3333, 8'h33, 8'h33};
    vecs[13] = '{16'h4444, 8'h44, 8'h44};
    vecs[14] = '{16'h5555, 8'h55, 8'h55};
    vecs[15] = '{16'h6666, 8'h66, 8'h66};
    vecs[16] = '{16'h7777, 8'h77, 8'h77};
    vecs[17] = '{16'h8888, 8'h88, 8'h88};
    vecs[18] = '{16'h9999, 8'h99, 8'h99};
    vecs[19] = '{16'hAAAA, 8'hAA, 8'hAA};

    $display("[TB] reset and single word");
    resetDut();
    applyStimulus(vecs[0], 1'b1);
    checkOutput("emptyAfterWr", empty, 0);
    checkOutput("txBeforePop", tx, 1);
    @(posedge clk);
    #1;
    checkOutput("startBitTx", tx, 0);
    checkOutput("busyInFrame", busy, 1);
    checkOutput("emptyAfterPop", empty, 1);
    repeat (20 * CPB - 1) @(posedge clk);
    #1;
    checkOutput("lastStopTx", tx, 1);
    checkOutput("lastStopBusy", busy, 1);
    @(posedge clk);
    #1;
    checkOutput("busyFallen", busy, 0);
    checkOutput("idleTx", tx, 1);
    waitDrain("drainSingle", 200);

    $display("[TB] reset mid-frame");
    applyStimulus(vecs[0], 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("txLowBeforeReset", tx, 0);
    reset = 1'b0;
    #1;
    checkOutput("asyncResetTx", tx, 1);
    checkOutput("asyncResetEmpty", empty, 1);
    checkOutput("asyncResetBusy", busy, 0);
    sbQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back words");
    resetDut();
    windowStart = sampleCyc;
    for (int i = 1; i <= 3; i++)
      applyStimulus(vecs[i], 1'b1);
    waitDrain("drainB2B", 600);
    maxSpacing = 0;
    for (int i = 1; i < startLog.size(); i++)
      if (startLog[i - 1] >= windowStart && startLog[i] - startLog[i - 1] > maxSpacing)
        maxSpacing = startLog[i] - startLog[i - 1];
    checkOutput("wordSpacing", maxSpacing, 10 * CPB + 1);

    $display("[TB] fill and overflow");
    resetDut();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[4 + i], (i < 5));
      if (i == 4) begin
        checkOutput("fullAfter5", full, 1);
        checkOutput("noOverflowYet", overflow, 0);
      end
      if (i == 5) begin
        checkOutput("overflowSet", overflow, 1);
        checkOutput("fullAfter6", full, 1);
      end
    end
    waitDrain("drainOverflow", 1000);
    checkOutput("overflowSticky", overflow, 1);
    checkOutput("emptyAfterDrain", empty, 1);

    $display("[TB] push and pop while full");
    resetDut();
    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[4 + i], 1'b1);
    checkOutput("ppFullBefore", full, 1);
    repeat (20 * CPB - 3) @(posedge clk);
    #1;
    checkOutput("ppStillFull", full, 1);
    checkOutput("ppIdleTx", tx, 1);
    applyStimulus(vecs[0], 1'b1);
    checkOutput("ppFullAfter", full, 1);
    checkOutput("ppNoOverflow", overflow, 0);
    checkOutput("ppStartBit", tx, 0);
    waitDrain("drainPushPop", 1200);
    checkOutput("ppOverflowEnd", overflow, 0);

    $display("[TB] pointer wrap");
    resetDut();
    for (int i = 0; i < 10; i++) begin
      checkOutput("notFullBeforeWr", full, 0);
      applyStimulus(vecs[10 + i], 1'b1);
      repeat (59) @(posedge clk);
      #1;
    end
    waitDrain("drainWrap", 2000);
    checkOutput("wrapNoOverflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
